stack_data_memory: RTL and testbench

Parametrised data-memory stage with a hardware stack: single-port word memory serving load/store plus single-word and double-word push/pop, with overflow/underflow detection. Sits in the memory stage of the pipeline after execute; double-word push/pop carries 32-bit PC/flags for CALL/RET/INT/RTI. A `busy` output stalls upstream stages for the extra cycle of double-word operations.

---
 rtl/stack_data_memory.sv | 167 ++++++++++++++++
 tb/tb_stack_data_memory.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/stack_data_memory.sv
// Memory stage with a full-descending hardware stack. Single-port word memory
// that serves loads/stores plus single- and double-word push/pop. Double-word
// operations take two cycles and raise `busy` for the second one.
module stack_data_memory #(
    parameter int DATA_W  = 16,
    parameter int ADDR_W  = 11,
    parameter int SP_INIT = 2**ADDR_W - 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  mem_read,
    input  logic                  mem_write,
    input  logic                  mem_push,
    input  logic                  mem_pop,
    input  logic                  wide,
    input  logic [ADDR_W-1:0]     address,
    input  logic [2*DATA_W-1:0]   write_data,
    output logic [2*DATA_W-1:0]   read_data,
    output logic                  read_valid,
    output logic                  busy,
    output logic [ADDR_W-1:0]     sp,
    output logic                  stack_overflow,
    output logic                  stack_underflow
);

    // state    | meaning
    // IDLE     | accepting requests
    // PUSH_LO  | second cycle of wide push: low half goes to mem[sp-2]
    // POP_HI   | second cycle of wide pop: high half read from mem[sp+1]
    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_PUSH_LO = 2'd1;
    localparam logic [1:0] ST_POP_HI  = 2'd2;

    localparam int                DEPTH    = 2**ADDR_W;
    localparam logic [ADDR_W-1:0] SP_EMPTY = ADDR_W'(SP_INIT);
    localparam logic [ADDR_W-1:0] ONE      = ADDR_W'(1);
    localparam logic [ADDR_W-1:0] TWO      = ADDR_W'(2);

    logic [DATA_W-1:0] mem [DEPTH];

    logic [1:0]        state;
    // Low half of the wide op in flight (push data or first popped word).
    logic [DATA_W-1:0] hold_word;

    logic              idle;
    logic              req_push, req_pop, req_write, req_read;
    logic              push_reject, pop_reject;
    logic              push_ok;
    logic [ADDR_W-1:0] sp_m1, sp_m2, sp_p1, sp_p2;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_waddr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] top_word, next_word, addr_word;

    assign idle  = (state == ST_IDLE);
    assign busy  = ~idle;
    assign sp_m1 = sp - ONE;
    assign sp_m2 = sp - TWO;
    assign sp_p1 = sp + ONE;
    assign sp_p2 = sp + TWO;

    // Fixed-priority request decode: push > pop > write > read.
    always_comb begin
        req_push  = idle & mem_push;
        req_pop   = idle & ~mem_push & mem_pop;
        req_write = idle & ~mem_push & ~mem_pop & mem_write;
        req_read  = idle & ~mem_push & ~mem_pop & ~mem_write & mem_read;
    end

    // Bounds checks; these also guarantee sp never wraps.
    always_comb begin
        push_reject = wide ? (sp < TWO) : (sp == '0);
        pop_reject  = wide ? (sp > (SP_EMPTY - TWO)) : (sp == SP_EMPTY);
        push_ok     = req_push & ~push_reject;
    end

    assign top_word  = mem[sp];
    assign next_word = mem[sp_p1];
    assign addr_word = mem[address];

    // Single write port shared by store, push and the second half of wide push.
    always_comb begin
        mem_we    = 1'b0;
        mem_waddr = sp_m1;
        mem_wdata = write_data[DATA_W-1:0];
        if (state == ST_PUSH_LO) begin
            mem_we    = 1'b1;
            mem_waddr = sp_m2;
            mem_wdata = hold_word;
        end else if (push_ok) begin
            mem_we    = 1'b1;
            mem_waddr = sp_m1;
            mem_wdata = wide ? write_data[2*DATA_W-1:DATA_W] : write_data[DATA_W-1:0];
        end else if (req_write) begin
            mem_we    = 1'b1;
            mem_waddr = address;
            mem_wdata = write_data[DATA_W-1:0];
        end
    end

    // Memory array: contents survive reset.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[mem_waddr] <= mem_wdata;
        end
    end

    // Sequencer, stack pointer and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state           <= ST_IDLE;
            sp              <= SP_EMPTY;
            hold_word       <= '0;
            read_data       <= '0;
            read_valid      <= 1'b0;
            stack_overflow  <= 1'b0;
            stack_underflow <= 1'b0;
        end else begin
            read_valid      <= 1'b0;
            stack_overflow  <= 1'b0;
            stack_underflow <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (req_push) begin
                        if (push_reject) begin
                            stack_overflow <= 1'b1;
                        end else if (wide) begin
                            hold_word <= write_data[DATA_W-1:0];
                            state     <= ST_PUSH_LO;
                        end else begin
                            sp <= sp_m1;
                        end
                    end else if (req_pop) begin
                        if (pop_reject) begin
                            stack_underflow <= 1'b1;
                        end else if (wide) begin
                            hold_word <= top_word;
                            state     <= ST_POP_HI;
                        end else begin
                            read_data  <= {{DATA_W{1'b0}}, top_word};
                            read_valid <= 1'b1;
                            sp         <= sp_p1;
                        end
                    end else if (req_read) begin
                        read_data  <= {{DATA_W{1'b0}}, addr_word};
                        read_valid <= 1'b1;
                    end
                end
                ST_PUSH_LO: begin
                    // sp moves only once, after both halves are in memory.
                    sp    <= sp_m2;
                    state <= ST_IDLE;
                end
                ST_POP_HI: begin
                    read_data  <= {next_word, hold_word};
                    read_valid <= 1'b1;
                    sp         <= sp_p2;
                    state      <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_stack_data_memory.sv
// Scoreboard bench for stack_data_memory: the driver updates an array/integer
// model of memory and stack pointer and queues expected outputs; a monitor
// pops and compares whenever the DUT presents data or a flag.
module tb_stack_data_memory;
    localparam int DW  = 16;
    localparam int AW  = 11;
    localparam int SPI = 2047;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            mem_read, mem_write, mem_push, mem_pop, wide;
    logic [AW-1:0]   address;
    logic [2*DW-1:0] write_data;
    logic [2*DW-1:0] read_data;
    logic            read_valid, busy, stack_overflow, stack_underflow;
    logic [AW-1:0]   sp;

    stack_data_memory #(.DATA_W(DW), .ADDR_W(AW), .SP_INIT(SPI)) dut (
        .clk(clk), .rst_n(rst_n),
        .mem_read(mem_read), .mem_write(mem_write),
        .mem_push(mem_push), .mem_pop(mem_pop), .wide(wide),
        .address(address), .write_data(write_data),
        .read_data(read_data), .read_valid(read_valid), .busy(busy), .sp(sp),
        .stack_overflow(stack_overflow), .stack_underflow(stack_underflow)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          kind;   // 0 data, 1 overflow, 2 underflow
        logic [31:0] data;
    } exp_t;

    exp_t        sb[$];
    logic [15:0] mm [2048];
    int          msp;
    int          total = 0;
    int          bad   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, want);
        end
    endtask

    task automatic clear_inputs();
        mem_read = 0; mem_write = 0; mem_push = 0; mem_pop = 0; wide = 0;
        address = '0; write_data = '0;
    endtask

    // Monitor: every output event must match the head of the scoreboard.
    initial begin
        exp_t e;
        int   k;
        forever begin
            @(negedge clk);
            if (rst_n === 1'b1 && (read_valid || stack_overflow || stack_underflow)) begin
                k = read_valid ? 0 : (stack_overflow ? 1 : 2);
                total++;
                if ((int'(read_valid) + int'(stack_overflow) + int'(stack_underflow)) > 1) begin
                    bad++;
                    $display("FAIL sb_multi: got rv=%b ovf=%b unf=%b expected one event",
                             read_valid, stack_overflow, stack_underflow);
                end else if (sb.size() == 0) begin
                    bad++;
                    $display("FAIL sb_unexpected: got kind %0d data %h expected nothing", k, read_data);
                end else begin
                    e = sb.pop_front();
                    if (e.kind != k || (k == 0 && read_data !== e.data)) begin
                        bad++;
                        $display("FAIL sb_event: got kind %0d data %h expected kind %0d data %h",
                                 k, read_data, e.kind, e.data);
                    end
                end
            end
        end
    end

    // Issue one request at a negedge; model decides what the DUT must do.
    task automatic issue(input bit p_push, input bit p_pop, input bit p_wr, input bit p_rd,
                         input bit p_wide, input logic [AW-1:0] a, input logic [31:0] d);
        bit exp_busy;
        int old_sp;
        exp_busy = 0;
        old_sp   = msp;
        chk("sp_before", 32'(sp), 32'(msp));
        chk("idle_before", 32'(busy), 32'd0);
        mem_push = p_push; mem_pop = p_pop; mem_write = p_wr; mem_read = p_rd;
        wide = p_wide; address = a; write_data = d;
        if (p_push) begin
            if (p_wide) begin
                if (msp < 2) sb.push_back('{1, 32'd0});
                else begin
                    mm[msp-1] = d[31:16];
                    mm[msp-2] = d[15:0];
                    msp -= 2;
                    exp_busy = 1;
                end
            end else begin
                if (msp == 0) sb.push_back('{1, 32'd0});
                else begin
                    msp -= 1;
                    mm[msp] = d[15:0];
                end
            end
        end else if (p_pop) begin
            if (p_wide) begin
                if (msp > SPI - 2) sb.push_back('{2, 32'd0});
                else begin
                    sb.push_back('{0, {mm[msp+1], mm[msp]}});
                    msp += 2;
                    exp_busy = 1;
                end
            end else begin
                if (msp == SPI) sb.push_back('{2, 32'd0});
                else begin
                    sb.push_back('{0, {16'h0, mm[msp]}});
                    msp += 1;
                end
            end
        end else if (p_wr) begin
            mm[a] = d[15:0];
        end else if (p_rd) begin
            sb.push_back('{0, {16'h0, mm[a]}});
        end
        @(negedge clk);
        if (exp_busy) begin
            chk("busy_mid", 32'(busy), 32'd1);
            chk("sp_mid", 32'(sp), 32'(old_sp));
            // Junk requests during the busy cycle must be ignored.
            mem_push = 1'($urandom); mem_pop = 1'($urandom);
            mem_write = 1'($urandom); mem_read = 1'($urandom);
            wide = 1'($urandom); address = AW'($urandom_range(0, 31));
            write_data = $urandom;
            @(negedge clk);
        end
        clear_inputs();
    endtask

    task automatic rand_op();
        int          r;
        bit          pu, po, wr, rd;
        logic [10:0] a;
        r  = $urandom_range(0, 9);
        pu = 0; po = 0; wr = 0; rd = 0;
        if (r <= 2) begin
            pu = 1; po = 1'($urandom); wr = 1'($urandom); rd = 1'($urandom);
        end else if (r <= 5) begin
            po = 1; wr = 1'($urandom); rd = 1'($urandom);
        end else if (r <= 7) begin
            wr = 1; rd = 1'($urandom);
        end else begin
            rd = 1;
        end
        a = ($urandom_range(0, 7) == 0) ? 11'd2047 : 11'($urandom_range(0, 31));
        if (wr && !pu && !po && a == 11'd2047) a = 11'd5;
        issue(pu, po, wr, rd, 1'($urandom), a, $urandom);
    endtask

    initial begin
        for (int i = 0; i < 2048; i++) mm[i] = '0;
        msp = SPI;
        clear_inputs();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_sp", 32'(sp), 32'(SPI));
        chk("rst_read_data", read_data, 32'd0);
        chk("rst_read_valid", 32'(read_valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_ovf", 32'(stack_overflow), 32'd0);
        chk("rst_unf", 32'(stack_underflow), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Known contents for the load/store region and the never-pushed top word.
        issue(0, 0, 1, 0, 0, 11'd2047, 32'h0000_5A5A);
        for (int i = 0; i < 32; i++) issue(0, 0, 1, 0, 0, 11'(i), $urandom);

        // Single push/pop ordering.
        issue(1, 0, 0, 0, 0, 11'd0, 32'h0000_1234);
        issue(1, 0, 0, 0, 0, 11'd0, 32'h0000_BEEF);
        issue(0, 1, 0, 0, 0, 11'd0, 32'd0);
        issue(0, 1, 0, 0, 0, 11'd0, 32'd0);

        // Wide push, inspect both halves, wide pop.
        issue(1, 0, 0, 0, 1, 11'd0, 32'hCAFE_0042);
        issue(0, 0, 0, 1, 0, 11'd2046, 32'd0);
        issue(0, 0, 0, 1, 0, 11'd2045, 32'd0);
        issue(0, 1, 0, 0, 1, 11'd0, 32'd0);

        // Underflow cases.
        issue(0, 1, 0, 0, 0, 11'd0, 32'd0);
        issue(1, 0, 0, 0, 0, 11'd0, 32'h0000_7777);
        issue(0, 1, 0, 0, 1, 11'd0, 32'd0);
        issue(0, 1, 0, 0, 0, 11'd0, 32'd0);

        // Store/load and priority of push over read.
        issue(0, 0, 1, 0, 0, 11'h10, 32'h0000_00A5);
        issue(0, 0, 0, 1, 0, 11'h10, 32'd0);
        issue(1, 0, 0, 1, 0, 11'h10, 32'h0000_4321);
        issue(0, 1, 0, 0, 0, 11'd0, 32'd0);

        // Random mix.
        for (int i = 0; i < 400; i++) rand_op();

        // Fill to the bottom, then overflow checks.
        while (msp > 0) issue(1, 0, 0, 0, 0, 11'd0, $urandom);
        issue(1, 0, 0, 0, 0, 11'd0, 32'h0000_DEAD);
        issue(0, 0, 0, 1, 0, 11'd2047, 32'd0);
        issue(0, 1, 0, 0, 0, 11'd0, 32'd0);
        issue(1, 0, 0, 0, 1, 11'd0, 32'hFFFF_EEEE);
        issue(0, 0, 0, 1, 0, 11'd0, 32'd0);

        // Drain, mixing wide and single pops.
        while (msp < SPI) begin
            if (msp <= SPI - 2 && $urandom_range(0, 1) == 1) issue(0, 1, 0, 0, 1, 11'd0, 32'd0);
            else issue(0, 1, 0, 0, 0, 11'd0, 32'd0);
        end

        // Reset asserted in the middle of a wide push.
        issue(1, 0, 0, 0, 1, 11'd0, 32'h1111_2222);
        issue(0, 1, 0, 0, 1, 11'd0, 32'd0);
        repeat (2) @(negedge clk);
        mem_push = 1; wide = 1; write_data = 32'h3333_4444;
        @(posedge clk);
        #2;
        chk("pre_rst_busy", 32'(busy), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("async_rst_busy", 32'(busy), 32'd0);
        chk("async_rst_sp", 32'(sp), 32'(SPI));
        chk("async_rst_read_data", read_data, 32'd0);
        chk("async_rst_read_valid", 32'(read_valid), 32'd0);
        clear_inputs();
        mm[SPI-1] = 16'h3333;
        msp = SPI;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        issue(0, 0, 0, 1, 0, 11'd2046, 32'd0);
        issue(0, 1, 0, 0, 0, 11'd0, 32'd0);

        repeat (3) @(negedge clk);
        chk("sb_empty", 32'(sb.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
